// File: rtl/board_ram_scheduler_pkg.sv
// board_pkg: shared constants and state encoding for the board RAM scheduler.
// Tile status codes and board selects are used by the scheduler, the renderer and game logic.
// Provides the scheduler state enum, which is shared with anything that decodes the state.
package board_pkg;

  // Tile status codes stored in the board RAMs
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HIT   = 2'd1;
  localparam logic [1:0] MISS  = 2'd2;
  localparam logic [1:0] SHIP  = 2'd3;

  // Board select encoding carried with each command
  localparam logic US   = 1'b0;
  localparam logic THEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CLEAR   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/board_ram_scheduler_if.sv
// board_ram_scheduler_if: game-logic command, response and clear handshake.
// master = game controller; slave = scheduler. Commands use a valid/ready handshake,
// responses are a one-cycle rsp_valid pulse, and clear is a level request with a busy flag.
interface board_ram_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic              cmd_board;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              clear_req;
  logic              clear_busy;

  modport master (
    output cmd_valid, cmd_we, cmd_board, cmd_addr, cmd_wdata, clear_req,
    input  cmd_ready, rsp_valid, rsp_data, clear_busy
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_board, cmd_addr, cmd_wdata, clear_req,
    output cmd_ready, rsp_valid, rsp_data, clear_busy
  );

endinterface

// File: rtl/board_ram_scheduler_cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding queued game-logic commands.
// Latency: one cycle -- a pushed entry becomes visible at the head on the following cycle.
// Backpressure: full_o/cnt_o let the producer throttle; a push while full is taken only with a pop.
// Ports: clk, rst_n (async, active-low), push_i/din_i, pop_i/dout_o, full_o, empty_o, cnt_o.
module cmd_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Flags come from the registered count, so an entry pushed into an empty
  // FIFO cannot be popped in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/board_ram_scheduler.sv
// board_ram_scheduler: shares the single-port us/them board RAMs between the renderer and game logic.
// Latency: video reads pass straight through; a queued read answers 2 cycles after its pop.
// Backpressure: cmd_ready drops when the command FIFO is full or a clear is pending/running.
// Ports: clk, rst (async active-low), vid_on, *_vid_addr/*_vid_data (renderer),
//        gl (command/response/clear interface, slave side), *_ram_addr/we/din/dout (board RAMs).
// Game-logic work only touches the RAMs while vid_on=0, so renderer reads are never disturbed.
module board_ram_scheduler
  import board_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vid_on,
  input  logic [ADDR_W-1:0]    us_vid_addr,
  input  logic [ADDR_W-1:0]    them_vid_addr,
  output logic [DATA_W-1:0]    us_vid_data,
  output logic [DATA_W-1:0]    them_vid_data,
  board_ram_scheduler_if.slave gl,
  output logic [ADDR_W-1:0]    us_ram_addr,
  output logic                 us_ram_we,
  output logic [DATA_W-1:0]    us_ram_din,
  input  logic [DATA_W-1:0]    us_ram_dout,
  output logic [ADDR_W-1:0]    them_ram_addr,
  output logic                 them_ram_we,
  output logic [DATA_W-1:0]    them_ram_din,
  input  logic [DATA_W-1:0]    them_ram_dout
);

  localparam int CMD_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_e      state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clear_pending_q;
  logic              clear_busy_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rd_board_q;

  logic              clear_pending_d;
  logic              clear_busy_d;
  logic              cmd_ready_d;

  logic [CMD_W-1:0]  push_dat;
  logic [CMD_W-1:0]  head_dat;
  logic              head_we;
  logic              head_board;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  fifo_cnt_d;

  logic              push;
  logic              pop;
  logic              go_clear;
  logic              clr_wr;
  logic              clr_last;
  logic              clr_done;
  logic              clear_start;

  logic [ADDR_W-1:0] us_sched_addr;
  logic              us_sched_we;
  logic [DATA_W-1:0] us_sched_din;
  logic [ADDR_W-1:0] them_sched_addr;
  logic              them_sched_we;
  logic [DATA_W-1:0] them_sched_din;

  // ---------------------------------------------------------------- command FIFO
  assign push_dat = {gl.cmd_we, gl.cmd_board, gl.cmd_addr, gl.cmd_wdata};
  assign {head_we, head_board, head_addr, head_wdata} = head_dat;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .din_i   (push_dat),
    .pop_i   (pop),
    .dout_o  (head_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  // ---------------------------------------------------------------- control terms
  assign push        = gl.cmd_valid && cmd_ready_q;
  // Pops happen only in blanking; the popped command drives the RAM in this same cycle.
  assign pop         = (state_q == IDLE) && !vid_on && !fifo_empty;
  assign go_clear    = (state_q == IDLE) && clear_pending_q && fifo_empty;
  assign clr_wr      = (state_q == CLEAR) && !vid_on;
  assign clr_last    = (clr_cnt_q == {ADDR_W{1'b1}});
  assign clr_done    = clr_wr && clr_last;
  assign clear_start = gl.clear_req && !clear_busy_q;

  assign clear_pending_d = clear_start || (clear_pending_q && !go_clear);
  assign clear_busy_d    = clear_start || (clear_busy_q && !clr_done);
  assign fifo_cnt_d      = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  // Ready is computed from next-cycle occupancy so a registered ready can never overfill the FIFO.
  assign cmd_ready_d     = (fifo_cnt_d != CNT_W'(FIFO_DEPTH)) && !clear_pending_d && !clear_busy_d;

  // ---------------------------------------------------------------- scheduler FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      clr_cnt_q       <= '0;
      clear_pending_q <= 1'b0;
      clear_busy_q    <= 1'b0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rd_board_q      <= US;
    end else begin
      rsp_valid_q     <= 1'b0;
      clear_pending_q <= clear_pending_d;
      clear_busy_q    <= clear_busy_d;
      cmd_ready_q     <= cmd_ready_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (!head_we) begin
              rd_board_q <= head_board;
              state_q    <= RD_WAIT;
            end
          end else if (go_clear) begin
            clr_cnt_q <= '0;
            state_q   <= CLEAR;
          end
        end
        RD_WAIT: begin
          // Address went out on the pop cycle, so dout is valid now even if vid_on just rose.
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= (rd_board_q == THEM) ? them_ram_dout : us_ram_dout;
          state_q     <= IDLE;
        end
        CLEAR: begin
          // Counter only advances on cycles where the write really reached the RAMs.
          if (clr_wr) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- scheduler-side RAM drive
  always_comb begin
    us_sched_addr   = '0;
    us_sched_we     = 1'b0;
    us_sched_din    = '0;
    them_sched_addr = '0;
    them_sched_we   = 1'b0;
    them_sched_din  = '0;
    if (pop) begin
      if (head_board == US) begin
        us_sched_addr = head_addr;
        us_sched_we   = head_we;
        us_sched_din  = head_we ? head_wdata : '0;
      end else begin
        them_sched_addr = head_addr;
        them_sched_we   = head_we;
        them_sched_din  = head_we ? head_wdata : '0;
      end
    end else if (state_q == CLEAR) begin
      us_sched_addr   = clr_cnt_q;
      us_sched_we     = 1'b1;
      us_sched_din    = DATA_W'(EMPTY);
      them_sched_addr = clr_cnt_q;
      them_sched_we   = 1'b1;
      them_sched_din  = DATA_W'(EMPTY);
    end
  end

  // Active video owns the RAM address and always suppresses writes.
  assign us_ram_addr   = vid_on ? us_vid_addr : us_sched_addr;
  assign us_ram_we     = !vid_on && us_sched_we;
  assign us_ram_din    = us_sched_din;
  assign them_ram_addr = vid_on ? them_vid_addr : them_sched_addr;
  assign them_ram_we   = !vid_on && them_sched_we;
  assign them_ram_din  = them_sched_din;

  assign us_vid_data   = us_ram_dout;
  assign them_vid_data = them_ram_dout;

  assign gl.cmd_ready  = cmd_ready_q;
  assign gl.rsp_valid  = rsp_valid_q;
  assign gl.rsp_data   = rsp_data_q;
  assign gl.clear_busy = clear_busy_q;

endmodule

// File: doc/board_ram_scheduler.md
Name: board_ram_scheduler

Overview:
- Shares the single-port "us" and "them" board RAMs between the screen renderer and game logic.
- The screen renderer reads tile status every pixel while vid_on=1. Game logic issues queued tile reads and writes, plus a whole-board clear.
- Game-logic accesses are deferred to blanking (vid_on=0), so video reads are never disturbed.
- Sits between the game controller, the tile renderer and the two board RAMs.

Parameters:
- ADDR_W, 10, board RAM address width (row[9:5], col[4:0])
- DATA_W, 2, tile status width (EMPTY=0, HIT=1, MISS=2, SHIP=3)
- FIFO_DEPTH, 4, command FIFO entries (power of 2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- vid_on  in  1  active-video flag from the VGA timing block
- us_vid_addr  in  ADDR_W  renderer read address, us board
- them_vid_addr  in  ADDR_W  renderer read address, them board
- us_vid_data  out  DATA_W  us board read data to the renderer
- them_vid_data  out  DATA_W  them board read data to the renderer
- cmd_valid  in  1  game-logic command valid
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising clk edge
- cmd_we  in  1  1=write, 0=read
- cmd_board  in  1  0=us, 1=them
- cmd_addr  in  ADDR_W  tile address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_data  out  DATA_W  read result
- clear_req  in  1  request to clear both boards to EMPTY (level sampled each cycle)
- clear_busy  out  1  clear pending or in progress
- us_ram_addr  out  ADDR_W  us RAM address
- us_ram_we  out  1  us RAM write enable
- us_ram_din  out  DATA_W  us RAM write data
- us_ram_dout  in  DATA_W  us RAM read data, 1-cycle registered latency
- them_ram_addr, them_ram_we, them_ram_din, them_ram_dout  same as us_*, for the them board

Behaviour:
- Reset (rst=0, async):
  - FIFO empty; state IDLE; clear pending flag cleared.
  - rsp_valid=0, rsp_data=0, clear_busy=0, cmd_ready=0.
  - ram_we=0 and ram_din=0 on both boards.
- RAM address mux (combinational):
  - vid_on=1: ram_addr = vid_addr and ram_we = 0, regardless of state.
  - vid_on=0: ram_addr is driven by the scheduler registers.
- Video read data: vid_data = ram_dout, passed straight through with no added latency. Data is undefined while vid_on=0.
- cmd_ready = !fifo_full && !clear_pending && !clear_busy (registered; deasserted during reset).
- FIFO ordering:
  - Commands execute strictly in FIFO order.
  - A push and a pop in the same cycle is legal when the FIFO is full; it is also legal when empty, but the pushed entry is popped no earlier than the next cycle.
- States:
  - IDLE
    - vid_on=0 and FIFO non-empty: pop the head and drive its board's addr.
      - Write: we=1 and din=wdata for exactly one cycle; stay in IDLE.
      - Read: we=0; go to RD_WAIT.
    - Write throughput during blanking is one command per cycle.
    - A pop is issued only in a cycle where vid_on=0.
  - RD_WAIT
    - Next cycle: capture the selected board's ram_dout into rsp_data, pulse rsp_valid for 1 cycle, return to IDLE.
    - Latency is 2 cycles from pop to rsp_valid.
    - If vid_on rises during RD_WAIT, the read still completes with correct data, because the address was applied the previous cycle.
  - CLEAR
    - Entered from IDLE when clear_pending=1 and the FIFO is empty.
    - Walks an ADDR_W-bit counter from 0 to 2^ADDR_W-1, writing EMPTY to both boards at the same address each cycle with vid_on=0.
    - The counter holds while vid_on=1, so the clear pauses through active video.
    - After address 2^ADDR_W-1 is written, return to IDLE and clear clear_busy on the next cycle.
- Clear request handling:
  - clear_req=1 while idle sets clear_pending and asserts clear_busy on the next cycle.
  - Commands already in the FIFO drain before the clear starts.
  - clear_req while clear_busy=1 is ignored.
  - A command accepted in the same cycle clear_req is first seen is queued ahead of the clear.
- ram_we is never asserted while vid_on=1.
- Reset mid-operation (including mid-clear or RD_WAIT) abandons the work: no rsp_valid, FIFO flushed.

Decomposition:
- Shared package board_pkg holds:
  - tile status constants EMPTY, HIT, MISS, SHIP
  - board select constants US=0, THEM=1
  - state encodings IDLE, RD_WAIT, CLEAR
- One sub-module, cmd_fifo: synchronous FIFO, width 1+1+ADDR_W+DATA_W, depth FIFO_DEPTH, with full/empty flags and async active-low reset.

Test Plan:
1. vid_on=1 constant, us_vid_addr=0x123, RAM preloaded with 0x123=SHIP -> us_vid_data=3 one cycle after the address; cmd writes queued, ram_we never 1.
2. vid_on=0; push write them 0x045=HIT, then read them 0x045 -> write pulse on them_ram_we at the first pop cycle; rsp_valid pulse with rsp_data=1 two cycles after the read pop.
3. vid_on=1; push 5 commands -> cmd_ready=0 after 4 accepted; drop vid_on -> 4 commands execute in order, cmd_ready re-asserts.
4. Read popped, vid_on rises in RD_WAIT -> rsp_data equals the stored value; the renderer address is applied to the RAM that same cycle.
5. Preload random boards; clear_req with vid_on toggling 50% -> clear_busy high until address 1023 is written; all 1024 entries EMPTY on both boards; zero writes during vid_on=1.
6. rst=0 asserted mid-clear at address 300 -> all outputs return to reset values immediately; after release, addresses 301..1023 are unchanged and cmd_ready=1.
